time_digit_counter: RTL and testbench

Parametrised time-field counter, the generalised successor of the fixed 0–59 minute counter. One instance serves any clock/calendar field: seconds, minutes, hours, day-of-month, month or year-digit. It chains through `carry_in`/`carry_out` in count mode. In adjust mode it steps up/down from front-panel buttons, with hold-to-repeat. It supports a runtime-variable upper limit for day-of-month and a parallel load.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/time_digit_counter_if.sv | 36 +++
 rtl/btn_repeat.sv | 117 +++++++++++
 rtl/time_digit_counter.sv | 80 ++++++++
 tb/tb_time_digit_counter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// clock_pkg
// Shared definitions for the clock/calendar field counters.
//   - Field limit constants for seconds, minutes, hours, day-of-month and month.
//   - Auto-repeat FSM state encoding.
//   - clamp_int: saturate an integer into an inclusive range.
package clock_pkg;

    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int DAY_MIN   = 1;
    localparam int DAY_MAX   = 31;
    localparam int MONTH_MIN = 1;
    localparam int MONTH_MAX = 12;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Limits are compared as int so that a MIN_VAL of 0 never produces an
    // always-false unsigned comparison.
    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/time_digit_counter_if.sv
// time_digit_counter_if
// Groups the control, data and status signals of one time field counter.
//   master: drives en_1, carry_in, adjust, up, down, load, load_val, max_in;
//           observes value, carry_out, dbg_state.
//   slave : the counter itself.
// Handshake: there is no valid/ready pair; every input is a level sampled on
// each rising clk_1Hz edge, and every output is a registered level (carry_out
// is a one-cycle pulse) valid for the whole cycle after the edge.
interface time_digit_counter_if #(
    parameter int WIDTH = 6
);
    import clock_pkg::*;

    logic             en_1;
    logic             carry_in;
    logic             adjust;
    logic             up;
    logic             down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_in;
    logic [WIDTH-1:0] value;
    logic             carry_out;
    rpt_state_t       dbg_state;

    modport master (
        output en_1, carry_in, adjust, up, down, load, load_val, max_in,
        input  value, carry_out, dbg_state
    );

    modport slave (
        input  en_1, carry_in, adjust, up, down, load, load_val, max_in,
        output value, carry_out, dbg_state
    );

endinterface

// File: rtl/btn_repeat.sv
// btn_repeat
// Button edge detection with hold-to-repeat.
//   clk_1Hz, rst : clock and synchronous active-high reset
//   up, down     : debounced button levels
//   enable       : adjust mode active and no load this cycle
//   step_up/dn   : one-cycle step requests (same edge as the sampled press)
//   state        : current repeat FSM state, for observation
module btn_repeat
    import clock_pkg::*;
#(
    parameter int HOLD_CYC = 4,
    parameter int RATE_CYC = 2
) (
    input  logic       clk_1Hz,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       enable,
    output logic       step_up,
    output logic       step_dn,
    output rpt_state_t state
);

    localparam int CNT_MAX = (HOLD_CYC > RATE_CYC) ? HOLD_CYC : RATE_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(RATE_CYC - 1);

    rpt_state_t    state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dir_up, dir_up_nxt;
    logic          up_q, down_q;
    logic          press_up, press_dn, held, cancel, step;

    assign press_up = up & ~up_q & ~down;
    assign press_dn = down & ~down_q & ~up;
    // The latched button alone must still be down to keep the run going.
    assign held     = dir_up ? (up & ~down) : (down & ~up);
    assign cancel   = ~enable | (up & down);

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            state  <= RPT_IDLE;
            cnt    <= '0;
            dir_up <= 1'b0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dir_up <= dir_up_nxt;
            up_q   <= up;
            down_q <= down;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dir_up_nxt = dir_up;
        if (cancel) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (press_up | press_dn) begin
                        state_nxt  = RPT_HOLD;
                        cnt_nxt    = '0;
                        dir_up_nxt = press_up;
                    end
                end
                RPT_HOLD: begin
                    if (!held) begin
                        state_nxt = RPT_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        state_nxt = RPT_REPEAT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (!held) begin
                        state_nxt = RPT_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == RATE_LAST) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RPT_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        step = 1'b0;
        if (!cancel) begin
            case (state)
                RPT_IDLE:   step = press_up | press_dn;
                RPT_HOLD:   step = held & (cnt == HOLD_LAST);
                RPT_REPEAT: step = held & (cnt == RATE_LAST);
                default:    step = 1'b0;
            endcase
        end
        // In IDLE the direction comes from the press itself, later from the latch.
        step_up = step & ((state == RPT_IDLE) ? press_up : dir_up);
        step_dn = step & ((state == RPT_IDLE) ? press_dn : ~dir_up);
    end

endmodule

// File: rtl/time_digit_counter.sv
// time_digit_counter
// Generic clock/calendar field: counts on carry_in, steps from buttons in
// adjust mode, supports a runtime upper limit and parallel load.
//   clk_1Hz, rst : clock and synchronous active-high reset
//   bus          : time_digit_counter_if slave (controls, value, carry_out)
// Per-edge priority: rst > load > clamp to limit > adjust step > count.
module time_digit_counter
    import clock_pkg::*;
#(
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 59,
    parameter int WIDTH    = 6,
    parameter int RST_VAL  = MIN_VAL,
    parameter int HOLD_CYC = 4,
    parameter int RATE_CYC = 2
) (
    input logic                 clk_1Hz,
    input logic                 rst,
    time_digit_counter_if.slave bus
);

    logic [WIDTH-1:0] value_q;
    logic             carry_q;
    logic             step_up, step_dn;
    int               cur, lim, value_nxt;
    logic             carry_nxt;

    btn_repeat #(
        .HOLD_CYC (HOLD_CYC),
        .RATE_CYC (RATE_CYC)
    ) u_btn (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .up      (bus.up),
        .down    (bus.down),
        .enable  (bus.adjust & ~bus.load),
        .step_up (step_up),
        .step_dn (step_dn),
        .state   (bus.dbg_state)
    );

    assign cur = int'(value_q);
    // A max_in below MIN_VAL collapses the range to the single value MIN_VAL.
    assign lim = clamp_int(int'(bus.max_in), MIN_VAL, MAX_VAL);

    always_comb begin
        value_nxt = cur;
        carry_nxt = 1'b0;
        if (bus.load) begin
            value_nxt = clamp_int(int'(bus.load_val), MIN_VAL, lim);
        end else if (cur > lim) begin
            value_nxt = lim;
        end else if (step_up) begin
            value_nxt = (cur == lim) ? MIN_VAL : cur + 1;
        end else if (step_dn) begin
            value_nxt = (cur == MIN_VAL) ? lim : cur - 1;
        end else if (bus.en_1 & bus.carry_in & ~bus.adjust) begin
            if (cur == lim) begin
                value_nxt = MIN_VAL;
                carry_nxt = 1'b1;
            end else begin
                value_nxt = cur + 1;
            end
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            value_q <= WIDTH'(RST_VAL);
            carry_q <= 1'b0;
        end else begin
            value_q <= WIDTH'(value_nxt);
            carry_q <= carry_nxt;
        end
    end

    assign bus.value     = value_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_time_digit_counter.sv
// tb_time_digit_counter
// Table vectors and hand sequences on a default 0..59 field (dut_a) and a
// 1..31 day field (dut_b), then random stimulus compared to a reference model.
module tb_time_digit_counter;
    import clock_pkg::*;

    localparam int HOLD = 4;
    localparam int RATE = 2;

    logic clk;
    logic rst_a, rst_b;
    int   errors = 0;
    int   checks = 0;

    time_digit_counter_if #(.WIDTH(6)) bus_a();
    time_digit_counter_if #(.WIDTH(5)) bus_b();

    time_digit_counter #(
        .MIN_VAL(0), .MAX_VAL(59), .WIDTH(6), .RST_VAL(0),
        .HOLD_CYC(HOLD), .RATE_CYC(RATE)
    ) dut_a (
        .clk_1Hz (clk),
        .rst     (rst_a),
        .bus     (bus_a)
    );

    time_digit_counter #(
        .MIN_VAL(1), .MAX_VAL(31), .WIDTH(5), .RST_VAL(1),
        .HOLD_CYC(HOLD), .RATE_CYC(RATE)
    ) dut_b (
        .clk_1Hz (clk),
        .rst     (rst_b),
        .bus     (bus_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Auto-repeat described as "edges since the press": step at k=0, k=HOLD,
    // HOLD+RATE, HOLD+2*RATE, ...
    typedef struct {
        int value;
        int carry;
        int up_p;
        int dn_p;
        int run;   // +1 up run, -1 down run, 0 none
        int k;
    } m_t;

    m_t ma, mb;

    function automatic void mstep(inout m_t m, input int min_v, input int max_v,
                                  input int rst_v, input bit r, input bit en,
                                  input bit ci, input bit adj, input bit up,
                                  input bit dn, input bit ld, input int ld_val,
                                  input int mx);
        int lim;
        int step;
        if (r) begin
            m.value = rst_v; m.carry = 0; m.up_p = 0; m.dn_p = 0; m.run = 0; m.k = 0;
            return;
        end
        step = 0;
        if (!(adj && !ld) || (up && dn)) begin
            m.run = 0;
        end else if ((m.run == 1 && up) || (m.run == -1 && dn)) begin
            m.k = m.k + 1;
            if (m.k >= HOLD && ((m.k - HOLD) % RATE) == 0) step = m.run;
        end else if (m.run != 0) begin
            m.run = 0;
        end else if (up && m.up_p == 0) begin
            m.run = 1; m.k = 0; step = 1;
        end else if (dn && m.dn_p == 0) begin
            m.run = -1; m.k = 0; step = -1;
        end
        lim = (mx > max_v) ? max_v : mx;
        if (lim < min_v) lim = min_v;
        m.carry = 0;
        if (ld) begin
            m.value = (ld_val < min_v) ? min_v : ((ld_val > lim) ? lim : ld_val);
        end else if (m.value > lim) begin
            m.value = lim;
        end else if (step == 1) begin
            m.value = (m.value == lim) ? min_v : m.value + 1;
        end else if (step == -1) begin
            m.value = (m.value == min_v) ? lim : m.value - 1;
        end else if (en && ci && !adj) begin
            if (m.value == lim) begin
                m.value = min_v; m.carry = 1;
            end else begin
                m.value = m.value + 1;
            end
        end
        m.up_p = up;
        m.dn_p = dn;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        mstep(ma, 0, 59, 0, rst_a, bus_a.en_1, bus_a.carry_in, bus_a.adjust,
              bus_a.up, bus_a.down, bus_a.load, int'(bus_a.load_val), int'(bus_a.max_in));
        mstep(mb, 1, 31, 1, rst_b, bus_b.en_1, bus_b.carry_in, bus_b.adjust,
              bus_b.up, bus_b.down, bus_b.load, int'(bus_b.load_val), int'(bus_b.max_in));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit en, input bit ci, input bit adj, input bit up,
                           input bit dn, input bit ld, input int ldv, input int mx);
        bus_a.en_1 = en; bus_a.carry_in = ci; bus_a.adjust = adj;
        bus_a.up = up; bus_a.down = dn; bus_a.load = ld;
        bus_a.load_val = 6'(ldv); bus_a.max_in = 6'(mx);
    endtask

    task automatic drive_b(input bit en, input bit ci, input bit adj, input bit up,
                           input bit dn, input bit ld, input int ldv, input int mx);
        bus_b.en_1 = en; bus_b.carry_in = ci; bus_b.adjust = adj;
        bus_b.up = up; bus_b.down = dn; bus_b.load = ld;
        bus_b.load_val = 5'(ldv); bus_b.max_in = 5'(mx);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rst, en, ci, adj, up, dn, ld;
        int ld_val;
        int mx;
        int ev;
        int ec;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit en, input bit ci, input bit adj,
                                input bit up, input bit dn, input bit ld, input int ld_val,
                                input int mx, input int ev, input int ec);
        vec_t v;
        v.rst = rst; v.en = en; v.ci = ci; v.adj = adj; v.up = up; v.dn = dn; v.ld = ld;
        v.ld_val = ld_val; v.mx = mx; v.ev = ev; v.ec = ec;
        return v;
    endfunction

    vec_t tv[25];

    initial begin
        int hold_exp[10];
        //        rst en ci adj up dn ld ldv mx   val carry
        tv[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 59,  0, 0);
        tv[1]  = mk(0, 0, 0, 0, 0, 0, 1, 58, 59, 58, 0);
        tv[2]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 59, 59, 0);
        tv[3]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 59,  0, 1);
        tv[4]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 59,  0, 0);
        tv[5]  = mk(0, 0, 1, 0, 0, 0, 0,  0, 59,  0, 0);
        tv[6]  = mk(0, 0, 0, 1, 0, 1, 0,  0, 59, 59, 0);
        tv[7]  = mk(0, 0, 0, 1, 0, 0, 0,  0, 59, 59, 0);
        tv[8]  = mk(0, 1, 1, 1, 0, 0, 0,  0, 59, 59, 0);
        tv[9]  = mk(0, 1, 1, 1, 0, 0, 0,  0, 59, 59, 0);
        tv[10] = mk(0, 0, 0, 1, 1, 0, 0,  0, 59,  0, 0);
        tv[11] = mk(0, 0, 0, 1, 0, 0, 0,  0, 59,  0, 0);
        tv[12] = mk(0, 1, 1, 0, 0, 0, 0,  0, 59,  1, 0);
        tv[13] = mk(0, 0, 0, 0, 0, 0, 1, 63, 59, 59, 0);
        tv[14] = mk(0, 0, 0, 1, 1, 0, 1, 10, 59, 10, 0);
        tv[15] = mk(0, 0, 0, 1, 1, 0, 0,  0, 59, 10, 0);
        tv[16] = mk(0, 0, 0, 1, 0, 0, 0,  0, 59, 10, 0);
        tv[17] = mk(0, 0, 0, 1, 1, 1, 0,  0, 59, 10, 0);
        tv[18] = mk(0, 1, 1, 0, 0, 0, 0,  0, 20, 11, 0);
        tv[19] = mk(0, 1, 1, 0, 0, 0, 0,  0,  5,  5, 0);
        tv[20] = mk(0, 1, 1, 0, 0, 0, 0,  0,  5,  0, 1);
        tv[21] = mk(0, 0, 0, 0, 0, 0, 1, 63, 63, 59, 0);
        tv[22] = mk(0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0);
        tv[23] = mk(0, 0, 0, 0, 0, 0, 1,  7, 59,  7, 0);
        tv[24] = mk(1, 0, 0, 0, 0, 0, 1, 30, 59,  0, 0);

        // Steps at edges 0, 4, 6, 8 of a held up from 10.
        hold_exp = '{11, 11, 11, 11, 12, 12, 13, 13, 14, 14};

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0, 59);
        drive_b(0, 0, 0, 0, 0, 0, 0, 31);

        // ---- table vectors on dut_a ----
        for (int i = 0; i < 25; i++) begin
            rst_a = tv[i].rst;
            drive_a(tv[i].en, tv[i].ci, tv[i].adj, tv[i].up, tv[i].dn, tv[i].ld,
                    tv[i].ld_val, tv[i].mx);
            cycle();
            chk($sformatf("vec%0d value", i), int'(bus_a.value), tv[i].ev);
            chk($sformatf("vec%0d carry", i), int'(bus_a.carry_out), tv[i].ec);
        end

        // ---- hold-to-repeat from 10 ----
        rst_a = 1'b0;
        drive_a(0, 0, 0, 0, 0, 1, 10, 59);
        cycle();
        chk("hold preload", int'(bus_a.value), 10);
        for (int i = 0; i < 10; i++) begin
            drive_a(0, 0, 1, 1, 0, 0, 0, 59);
            cycle();
            chk($sformatf("hold edge%0d", i), int'(bus_a.value), hold_exp[i]);
            if (i == 0) chk("hold state", int'(bus_a.dbg_state), int'(RPT_HOLD));
            if (i == 4) chk("repeat state", int'(bus_a.dbg_state), int'(RPT_REPEAT));
        end
        for (int i = 0; i < 3; i++) begin
            drive_a(0, 0, 1, 0, 0, 0, 0, 59);
            cycle();
            chk($sformatf("release edge%0d", i), int'(bus_a.value), 14);
        end

        // ---- reset in the middle of REPEAT ----
        drive_a(0, 0, 0, 0, 0, 1, 29, 59);
        cycle();
        for (int i = 0; i < 9; i++) begin
            drive_a(0, 0, 1, 1, 0, 0, 0, 59);
            cycle();
        end
        chk("repeat reaches", int'(bus_a.value), 33);
        chk("repeat active", int'(bus_a.dbg_state), int'(RPT_REPEAT));
        rst_a = 1'b1;
        cycle();
        chk("mid-rst value", int'(bus_a.value), 0);
        chk("mid-rst carry", int'(bus_a.carry_out), 0);
        chk("mid-rst state", int'(bus_a.dbg_state), int'(RPT_IDLE));
        rst_a = 1'b0;
        cycle();
        chk("fresh press", int'(bus_a.value), 1);
        drive_a(0, 0, 0, 0, 0, 0, 0, 59);
        cycle();

        // ---- day field: clamp and wrap on dut_b ----
        cycle();
        chk("b reset", int'(bus_b.value), 1);
        rst_b = 1'b0;
        drive_b(0, 0, 0, 0, 0, 1, 31, 31);
        cycle();
        chk("b load31", int'(bus_b.value), 31);
        drive_b(0, 0, 0, 0, 0, 0, 0, 30);
        cycle();
        chk("b clamp", int'(bus_b.value), 30);
        chk("b clamp carry", int'(bus_b.carry_out), 0);
        drive_b(1, 1, 0, 0, 0, 0, 0, 30);
        cycle();
        chk("b wrap value", int'(bus_b.value), 1);
        chk("b wrap carry", int'(bus_b.carry_out), 1);
        drive_b(0, 0, 0, 0, 0, 0, 0, 30);
        cycle();
        chk("b carry drop", int'(bus_b.carry_out), 0);
        drive_b(0, 0, 0, 0, 0, 1, 0, 30);
        cycle();
        chk("b load sat low", int'(bus_b.value), 1);
        drive_b(0, 0, 1, 0, 1, 0, 0, 30);
        cycle();
        chk("b down wrap", int'(bus_b.value), 30);
        drive_b(0, 0, 0, 0, 0, 0, 0, 31);
        cycle();

        // ---- random stimulus against the model ----
        for (int n = 0; n < 1500; n++) begin
            rst_a = ($urandom_range(0, 63) == 0);
            rst_b = ($urandom_range(0, 63) == 0);
            bus_a.load     = ($urandom_range(0, 15) == 0);
            bus_a.load_val = 6'($urandom_range(0, 63));
            bus_a.en_1     = ($urandom_range(0, 3) != 0);
            bus_a.carry_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) bus_a.adjust = ~bus_a.adjust;
            if ($urandom_range(0, 5) == 0) bus_a.up = ~bus_a.up;
            if ($urandom_range(0, 9) == 0) bus_a.down = ~bus_a.down;
            if ($urandom_range(0, 15) == 0) bus_a.max_in = 6'($urandom_range(0, 63));
            else if ($urandom_range(0, 7) == 0) bus_a.max_in = 6'd59;
            bus_b.load     = ($urandom_range(0, 15) == 0);
            bus_b.load_val = 5'($urandom_range(0, 31));
            bus_b.en_1     = ($urandom_range(0, 3) != 0);
            bus_b.carry_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) bus_b.adjust = ~bus_b.adjust;
            if ($urandom_range(0, 9) == 0) bus_b.up = ~bus_b.up;
            if ($urandom_range(0, 5) == 0) bus_b.down = ~bus_b.down;
            if ($urandom_range(0, 15) == 0) bus_b.max_in = 5'($urandom_range(0, 31));
            else if ($urandom_range(0, 7) == 0) bus_b.max_in = 5'd31;
            cycle();
            chk($sformatf("rnd%0d a value", n), int'(bus_a.value), ma.value);
            chk($sformatf("rnd%0d a carry", n), int'(bus_a.carry_out), ma.carry);
            chk($sformatf("rnd%0d b value", n), int'(bus_b.value), mb.value);
            chk($sformatf("rnd%0d b carry", n), int'(bus_b.carry_out), mb.carry);
        end

        // ---- report ----
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
